// File: rtl/issue_scoreboard.sv
// Issue controller: 64-entry register busy scoreboard with RAW/WAW hazard
// detection, per-unit availability, and serialization of unit-7 instructions.
// Instructions issue in order with no bypass; the decode stage is held by stall.
module issue_scoreboard #(
  parameter int NWB   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [2:0]       dec_unit,
  input  logic [5:0]       dec_r1_rn,
  input  logic [5:0]       dec_r2_rn,
  input  logic [5:0]       dec_rd_rn,
  input  logic [5:0]       dec_rd2_rn,
  input  logic             dec_wr_rd,
  input  logic             dec_wr_rd2,
  input  logic [7:0]       unit_busy,
  input  logic [NWB-1:0]   wb_valid,
  input  logic [6*NWB-1:0] wb_rn,
  input  logic             flush,
  output logic             stall,
  output logic             issue_valid,
  output logic [63:0]      busy_vec,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             wb_err
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state, state_next;
  logic [63:0] clr, set, busy_next;
  logic        hazard;
  logic        wb_bad;
  logic        drained;

  // Writeback decode: clear mask and detection of retires to idle registers.
  always_comb begin
    clr    = '0;
    wb_bad = 1'b0;
    for (int unsigned k = 0; k < NWB; k++) begin
      if (wb_valid[k]) begin
        clr[wb_rn[6*k +: 6]] = 1'b1;
        if (wb_rn[6*k +: 6] != 6'd0 && !busy_vec[wb_rn[6*k +: 6]])
          wb_bad = 1'b1;
      end
    end
  end

  // Hazard check against the registered scoreboard only (no bypass).
  always_comb begin
    hazard = 1'b0;
    if (dec_r1_rn != 6'd0 && busy_vec[dec_r1_rn])               hazard = 1'b1;
    if (dec_r2_rn != 6'd0 && busy_vec[dec_r2_rn])               hazard = 1'b1;
    if (dec_wr_rd && dec_rd_rn != 6'd0 && busy_vec[dec_rd_rn])  hazard = 1'b1;
    if (dec_wr_rd2 && dec_rd2_rn != 6'd0 && busy_vec[dec_rd2_rn]) hazard = 1'b1;
    if (unit_busy[dec_unit])                                    hazard = 1'b1;
  end

  // Drain completes on the edge where the last pending bit retires, so the held
  // serializing instruction is evaluated in RUN on the very next cycle.
  assign drained = (busy_vec & ~clr) == '0;

  // Next-state and issue/stall decode.
  always_comb begin
    state_next  = state;
    issue_valid = 1'b0;
    case (state)
      RUN: begin
        if (dec_valid && !flush && dec_unit == 3'd7 && busy_vec != '0)
          state_next = DRAIN;
        else
          issue_valid = dec_valid & ~hazard & ~flush;
      end
      DRAIN: begin
        if (flush || drained)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    stall = dec_valid & ~flush & ~issue_valid;
  end

  // Scoreboard next value: set wins over clear; r0 is never pending.
  always_comb begin
    set = '0;
    if (issue_valid) begin
      if (dec_wr_rd)  set[dec_rd_rn]  = 1'b1;
      if (dec_wr_rd2) set[dec_rd2_rn] = 1'b1;
    end
    busy_next    = (busy_vec & ~clr) | set;
    busy_next[0] = 1'b0;
  end

  // State, scoreboard, sticky error and saturating stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      busy_vec  <= '0;
      wb_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_next;
      busy_vec <= busy_next;
      if (wb_bad)
        wb_err <= 1'b1;
      if (dec_valid && stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard with hand-computed
// expectations; the stall counter is narrowed to 4 bits to reach saturation.
module tb_issue_scoreboard;

  localparam int NWB   = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dec_valid;
  logic [2:0]       dec_unit;
  logic [5:0]       dec_r1_rn, dec_r2_rn, dec_rd_rn, dec_rd2_rn;
  logic             dec_wr_rd, dec_wr_rd2;
  logic [7:0]       unit_busy;
  logic [NWB-1:0]   wb_valid;
  logic [6*NWB-1:0] wb_rn;
  logic             flush;
  logic             stall, issue_valid;
  logic [63:0]      busy_vec;
  logic [CNT_W-1:0] stall_cnt;
  logic             wb_err;

  int tests  = 0;
  int errors = 0;

  issue_scoreboard #(.NWB(NWB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_unit(dec_unit),
    .dec_r1_rn(dec_r1_rn), .dec_r2_rn(dec_r2_rn),
    .dec_rd_rn(dec_rd_rn), .dec_rd2_rn(dec_rd2_rn),
    .dec_wr_rd(dec_wr_rd), .dec_wr_rd2(dec_wr_rd2),
    .unit_busy(unit_busy), .wb_valid(wb_valid), .wb_rn(wb_rn),
    .flush(flush), .stall(stall), .issue_valid(issue_valid),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dec_valid  = 1'b0; dec_unit  = 3'd0;
    dec_r1_rn  = 6'd0; dec_r2_rn = 6'd0; dec_rd_rn = 6'd0; dec_rd2_rn = 6'd0;
    dec_wr_rd  = 1'b0; dec_wr_rd2 = 1'b0;
    unit_busy  = 8'h00; wb_valid = '0; wb_rn = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2;
    // Reset state
    reset_dut();
    #1;
    check("rst_busy", busy_vec, 64'h0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_err", wb_err, 0);
    check("rst_stall", stall, 0);
    check("rst_issue", issue_valid, 0);

    // 1: RAW hazard on r5, writeback in cycle 3, consumer issues cycle 4
    reset_dut();
    dec_valid = 1'b1; dec_wr_rd = 1'b1; dec_rd_rn = 6'd5;
    #1 check("t1_issue_producer", issue_valid, 1);
    step();
    check("t1_busy5", busy_vec, 64'h20);
    dec_wr_rd = 1'b0; dec_rd_rn = 6'd0; dec_r1_rn = 6'd5;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin wb_valid = 2'b01; wb_rn = 12'd5; end
      #1;
      check("t1_stall", stall, 1);
      check("t1_no_issue", issue_valid, 0);
      step();
    end
    wb_valid = '0;
    check("t1_busy_clear", busy_vec, 64'h0);
    #1;
    check("t1_issue_consumer", issue_valid, 1);
    check("t1_stall_low", stall, 0);
    step();
    idle();
    check("t1_cnt", stall_cnt, 3);

    // 2: unit 2 busy for four cycles
    reset_dut();
    dec_valid = 1'b1; dec_unit = 3'd2; unit_busy = 8'h04;
    repeat (4) begin
      #1 check("t2_stall", stall, 1);
      step();
    end
    unit_busy = 8'h00;
    #1;
    check("t2_issue", issue_valid, 1);
    check("t2_cnt", stall_cnt, 4);
    step();
    idle();

    // 3: serializing op drains r3 (retires cycle 2) and r9 (retires cycle 6)
    reset_dut();
    dec_valid = 1'b1; dec_wr_rd = 1'b1; dec_rd_rn = 6'd3; dec_wr_rd2 = 1'b1; dec_rd2_rn = 6'd9;
    #1 check("t3_setup_issue", issue_valid, 1);
    step();
    check("t3_busy", busy_vec, 64'h208);
    dec_wr_rd = 1'b0; dec_wr_rd2 = 1'b0; dec_rd_rn = 6'd0; dec_rd2_rn = 6'd0; dec_unit = 3'd7;
    for (int c = 0; c <= 6; c++) begin
      wb_valid = '0; wb_rn = '0;
      if (c == 2) begin wb_valid = 2'b01; wb_rn = 12'd3; end
      if (c == 6) begin wb_valid = 2'b01; wb_rn = 12'd9; end
      #1;
      check("t3_stall", stall, 1);
      check("t3_no_issue", issue_valid, 0);
      step();
    end
    wb_valid = '0; wb_rn = '0;
    check("t3_busy_empty", busy_vec, 64'h0);
    #1 check("t3_issue_c7", issue_valid, 1);
    step();
    idle();
    check("t3_cnt", stall_cnt, 7);

    // 4: flush while draining returns to RUN, keeps busy bits
    reset_dut();
    dec_valid = 1'b1; dec_wr_rd = 1'b1; dec_rd_rn = 6'd3;
    step();
    dec_wr_rd = 1'b0; dec_rd_rn = 6'd0; dec_unit = 3'd7;
    #1 check("t4_enter_drain", stall, 1);
    step();
    flush = 1'b1;
    #1;
    check("t4_flush_stall", stall, 0);
    check("t4_flush_issue", issue_valid, 0);
    step();
    flush = 1'b0; dec_unit = 3'd0;
    check("t4_busy_kept", busy_vec, 64'h8);
    #1 check("t4_run_issue", issue_valid, 1);
    step();
    idle();

    // 5: rd==rd2 single bit; dual retire of same reg; r0 ignored; sticky error
    reset_dut();
    dec_valid = 1'b1; dec_wr_rd = 1'b1; dec_rd_rn = 6'd10; dec_wr_rd2 = 1'b1; dec_rd2_rn = 6'd10;
    step();
    idle();
    check("t5_rd_eq_rd2", busy_vec, 64'h400);
    wb_valid = 2'b11; wb_rn = {6'd10, 6'd10};
    step();
    wb_valid = '0;
    check("t5_dual_clear", busy_vec, 64'h0);
    check("t5_dual_no_err", wb_err, 0);
    dec_valid = 1'b1; dec_wr_rd = 1'b1; dec_rd_rn = 6'd7;
    step();
    idle();
    wb_valid = 2'b11; wb_rn = {6'd0, 6'd7};
    step();
    check("t5_r7_clear", busy_vec, 64'h0);
    check("t5_r0_no_err", wb_err, 0);
    wb_valid = 2'b01; wb_rn = 12'd12;
    step();
    wb_valid = '0;
    check("t5_err_set", wb_err, 1);
    step();
    check("t5_err_sticky", wb_err, 1);

    // 6: r0 destinations never busy; stall counter saturates
    reset_dut();
    dec_valid = 1'b1; dec_wr_rd = 1'b1; dec_wr_rd2 = 1'b1;
    #1 check("t6_issue_r0", issue_valid, 1);
    step();
    check("t6_busy_r0", busy_vec, 64'h0);
    dec_wr_rd = 1'b0; dec_wr_rd2 = 1'b0; dec_unit = 3'd1; unit_busy = 8'h02;
    repeat (14) step();
    check("t6_cnt14", stall_cnt, 14);
    step();
    check("t6_cnt15", stall_cnt, 15);
    repeat (3) step();
    check("t6_cnt_sat", stall_cnt, 15);
    idle();

    // 7: reset mid-operation, in-flight writeback flags error
    reset_dut();
    dec_valid = 1'b1; dec_wr_rd = 1'b1; dec_rd_rn = 6'd20;
    step();
    idle();
    check("t7_busy20", busy_vec, 64'h100000);
    #2 rst_n = 1'b0;
    #1 check("t7_async_clear", busy_vec, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_valid = 2'b01; wb_rn = 12'd20;
    step();
    wb_valid = '0;
    check("t7_stale_wb_err", wb_err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
